// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access unit: op encoding, word/byte types, and request formatting.
package Mem;

  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} op_t;
  typedef logic [29:0] waddr_t;
  typedef logic [31:0] w_t;

  typedef struct packed {
    waddr_t     addr;
    logic       we;
    logic [3:0] mask;
    w_t         wdata;
  } req_t;

  function automatic logic is_store(op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [3:0] access_mask(op_t op, logic [1:0] off);
    case (op)
      LB, LBU, SB: return 4'b0001 << off;
      LH, LHU, SH: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(op_t op, logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Replicate store data across lanes so the mask alone selects the bytes written.
  function automatic w_t store_data(op_t op, w_t wdata);
    case (op)
      SB:      return {4{wdata[7:0]}};
      SH:      return {2{wdata[15:0]}};
      SW:      return wdata;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/l1dcache_core_if.sv
// Word-addressed, byte-masked request/ack channel between a core-side client and the store queue.
interface l1dcache_core_if;
  logic        req_valid;
  logic [29:0] req_addr;
  logic        req_we;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        resp_ack;
  logic [31:0] resp_data;

  modport Client (
    output req_valid, req_addr, req_we, req_mask, req_wdata,
    input  resp_ack, resp_data
  );

  modport Server (
    input  req_valid, req_addr, req_we, req_mask, req_wdata,
    output resp_ack, resp_data
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load formatter: picks the byte/half addressed by the held offset and extends it.
module mem_load_align
  import Mem::*;
(
  input  w_t         i_resp_data,
  input  op_t        i_op,
  input  logic [1:0] i_off,
  output w_t         o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_resp_data[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_resp_data[31:16] : i_resp_data[15:0];

  always_comb begin
    o_data = i_resp_data;
    case (i_op)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_data = {24'h0, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LHU:     o_data = {16'h0, w_half};
      default: o_data = i_resp_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Aligns execute-stage load/store ops into masked word requests, reissuing until acked.
// Loads complete with formatted writeback data; misaligned ops report an exception next cycle.
module mem_access_unit
  import Mem::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  op_t                ex_op,
  input  logic [31:0]        ex_addr,
  input  logic [31:0]        ex_wdata,
  input  logic [4:0]         ex_rd,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               st_done,
  output logic               exc_valid,
  output logic               exc_store,
  output logic [31:0]        exc_addr,
  output logic [CNT_W-1:0]   retry_cnt,
  l1dcache_core_if.Client    dmem
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            r_state, w_state_nxt;
  op_t               r_op;
  logic [1:0]        r_off;
  logic [4:0]        r_rd;
  req_t              r_req;
  req_t              w_new_req;
  req_t              w_drv_req;
  logic [CNT_W-1:0]  r_retry_cnt;
  logic              r_exc_valid;
  logic              r_exc_store;
  logic [31:0]       r_exc_addr;
  logic              w_ack, w_accept, w_mis, w_issue, w_reissue, w_drv_vld;
  w_t                w_load_data;

  // Ack only means something while a request is outstanding.
  assign w_ack     = (r_state == PEND) && dmem.resp_ack;
  assign ex_ready  = (r_state == IDLE) || w_ack;
  assign w_accept  = ex_valid && ex_ready;
  assign w_mis     = is_misaligned(ex_op, ex_addr[1:0]);
  assign w_issue   = w_accept && !w_mis;
  assign w_reissue = (r_state == PEND) && !dmem.resp_ack;

  assign w_new_req.addr  = ex_addr[31:2];
  assign w_new_req.we    = is_store(ex_op);
  assign w_new_req.mask  = access_mask(ex_op, ex_addr[1:0]);
  assign w_new_req.wdata = store_data(ex_op, ex_wdata);

  always_comb begin
    w_state_nxt = IDLE;
    w_drv_vld   = 1'b0;
    w_drv_req   = '0;
    if (w_issue) begin
      w_state_nxt = PEND;
      w_drv_vld   = 1'b1;
      w_drv_req   = w_new_req;
    end else if (w_reissue) begin
      w_state_nxt = PEND;
      w_drv_vld   = 1'b1;
      w_drv_req   = r_req;
    end
  end

  assign dmem.req_valid = w_drv_vld;
  assign dmem.req_addr  = w_drv_req.addr;
  assign dmem.req_we    = w_drv_req.we;
  assign dmem.req_mask  = w_drv_req.mask;
  assign dmem.req_wdata = w_drv_req.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= LB;
      r_off       <= '0;
      r_rd        <= '0;
      r_req       <= '0;
      r_retry_cnt <= '0;
      r_exc_valid <= 1'b0;
      r_exc_store <= 1'b0;
      r_exc_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_exc_valid <= w_accept && w_mis;
      if (w_issue) begin
        r_op  <= ex_op;
        r_off <= ex_addr[1:0];
        r_rd  <= ex_rd;
        r_req <= w_new_req;
      end
      if (w_reissue && (r_retry_cnt != '1))
        r_retry_cnt <= r_retry_cnt + 1'b1;
      if (w_accept && w_mis) begin
        r_exc_store <= is_store(ex_op);
        r_exc_addr  <= ex_addr;
      end
    end
  end

  mem_load_align u_load_align (
    .i_resp_data (dmem.resp_data),
    .i_op        (r_op),
    .i_off       (r_off),
    .o_data      (w_load_data)
  );

  assign wb_valid  = w_ack && !is_store(r_op);
  assign st_done   = w_ack && is_store(r_op);
  assign wb_rd     = wb_valid ? r_rd : 5'd0;
  assign wb_data   = wb_valid ? w_load_data : 32'd0;
  assign exc_valid = r_exc_valid;
  assign exc_store = r_exc_store;
  assign exc_addr  = r_exc_addr;
  assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs driven on negedge, outputs checked 1ns later.
module tb_mem_access_unit;
  import Mem::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  op_t         ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        exc_valid;
  logic        exc_store;
  logic [31:0] exc_addr;
  logic [15:0] retry_cnt;
  logic        ack;
  logic [31:0] rdata;

  int n_total = 0;
  int n_bad   = 0;

  l1dcache_core_if u_if ();
  assign u_if.resp_ack  = ack;
  assign u_if.resp_data = rdata;

  mem_access_unit #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op     (ex_op),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_rd     (ex_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .st_done   (st_done),
    .exc_valid (exc_valid),
    .exc_store (exc_store),
    .exc_addr  (exc_addr),
    .retry_cnt (retry_cnt),
    .dmem      (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input op_t op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic a, input logic [31:0] rd_data);
    @(negedge clk);
    ex_valid = v;
    ex_op    = op;
    ex_addr  = addr;
    ex_wdata = wd;
    ex_rd    = rd;
    ack      = a;
    rdata    = rd_data;
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = LB; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    ack = 1'b0; rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_st_done", st_done, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_exc_addr", exc_addr, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_req_valid", u_if.req_valid, 0);

    // LW aligned, acked immediately
    drive(1, LW, 32'h100, 32'h0, 5'd5, 0, 32'h0);
    chk("lw_req_valid", u_if.req_valid, 1);
    chk("lw_req_addr", u_if.req_addr, 32'h40);
    chk("lw_mask", u_if.req_mask, 4'b1111);
    chk("lw_we", u_if.req_we, 0);
    chk("lw_wdata", u_if.req_wdata, 0);
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'hDEADBEEF);
    chk("lw_wb_valid", wb_valid, 1);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_wb_rd", wb_rd, 5);
    chk("lw_req_idle", u_if.req_valid, 0);

    // LB / LBU / LH formatting
    drive(1, LB, 32'h103, 32'h0, 5'd2, 0, 32'h0);
    chk("lb_mask", u_if.req_mask, 4'b1000);
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'h80123456);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    drive(1, LBU, 32'h103, 32'h0, 5'd2, 0, 32'h0);
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'h80123456);
    chk("lbu_data", wb_data, 32'h00000080);
    drive(1, LH, 32'h102, 32'h0, 5'd2, 0, 32'h0);
    chk("lh_mask", u_if.req_mask, 4'b1100);
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'h80015678);
    chk("lh_data", wb_data, 32'hFFFF8001);

    // SH with two withheld acks
    drive(1, SH, 32'h206, 32'h1234ABCD, 5'd0, 0, 32'h0);
    chk("sh_addr", u_if.req_addr, 32'h81);
    chk("sh_mask", u_if.req_mask, 4'b1100);
    chk("sh_wdata", u_if.req_wdata, 32'hABCDABCD);
    chk("sh_we", u_if.req_we, 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, LB, 32'h0, 32'h0, 5'd0, 0, 32'h0);
      chk("sh_re_valid", u_if.req_valid, 1);
      chk("sh_re_mask", u_if.req_mask, 4'b1100);
      chk("sh_re_wdata", u_if.req_wdata, 32'hABCDABCD);
      chk("sh_re_addr", u_if.req_addr, 32'h81);
      chk("sh_re_ready", ex_ready, 0);
      chk("sh_re_done", st_done, 0);
    end
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'h0);
    chk("sh_st_done", st_done, 1);
    chk("sh_wb_valid", wb_valid, 0);
    chk("sh_retry", retry_cnt, 2);
    chk("sh_ready", ex_ready, 1);

    // Misaligned SW
    drive(1, SW, 32'h301, 32'h0, 5'd0, 0, 32'h0);
    chk("sw_mis_noreq", u_if.req_valid, 0);
    chk("sw_mis_ready", ex_ready, 1);
    drive(0, LB, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    chk("sw_exc_valid", exc_valid, 1);
    chk("sw_exc_store", exc_store, 1);
    chk("sw_exc_addr", exc_addr, 32'h301);
    chk("sw_noreq2", u_if.req_valid, 0);
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'h0);
    chk("sw_exc_pulse", exc_valid, 0);
    chk("idle_ack_ignored", wb_valid | st_done, 0);

    // Back-to-back LW, SB, LW
    drive(1, LW, 32'h10, 32'h0, 5'd1, 0, 32'h0);
    chk("b2b0_valid", u_if.req_valid, 1);
    chk("b2b0_addr", u_if.req_addr, 32'h4);
    drive(1, SB, 32'h21, 32'h000000A5, 5'd0, 1, 32'h11111111);
    chk("b2b1_wb_valid", wb_valid, 1);
    chk("b2b1_wb_data", wb_data, 32'h11111111);
    chk("b2b1_wb_rd", wb_rd, 1);
    chk("b2b1_ready", ex_ready, 1);
    chk("b2b1_valid", u_if.req_valid, 1);
    chk("b2b1_addr", u_if.req_addr, 32'h8);
    chk("b2b1_mask", u_if.req_mask, 4'b0010);
    chk("b2b1_wdata", u_if.req_wdata, 32'hA5A5A5A5);
    drive(1, LW, 32'h30, 32'h0, 5'd3, 1, 32'h0);
    chk("b2b2_st_done", st_done, 1);
    chk("b2b2_ready", ex_ready, 1);
    chk("b2b2_valid", u_if.req_valid, 1);
    chk("b2b2_addr", u_if.req_addr, 32'hC);
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'h22222222);
    chk("b2b3_wb_valid", wb_valid, 1);
    chk("b2b3_wb_data", wb_data, 32'h22222222);
    chk("b2b3_wb_rd", wb_rd, 3);
    chk("b2b3_noreq", u_if.req_valid, 0);

    // Reset while a load is outstanding
    drive(1, LW, 32'h40, 32'h0, 5'd7, 0, 32'h0);
    chk("rstp_issue", u_if.req_valid, 1);
    @(negedge clk);
    rst = 1'b1; ex_valid = 1'b0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, LB, 32'h0, 32'h0, 5'd0, 1, 32'h33333333);
    chk("rstp_wb_valid", wb_valid, 0);
    chk("rstp_ready", ex_ready, 1);
    chk("rstp_retry", retry_cnt, 0);
    chk("rstp_noreq", u_if.req_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Upstream neighbour of the store queue: takes byte-addressed load/store ops from the execute stage, aligns them into word-addressed, byte-masked requests on an `l1dcache_core_if` client port, and retries until acknowledged. Loads return formatted (sign/zero-extended) results to writeback; stores complete on queue acceptance. Misaligned accesses raise an exception without touching memory.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating retry counter.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ex_valid`  in  1  memory op presented
- `ex_ready`  out  1  op accepted this cycle when `ex_valid && ex_ready`
- `ex_op`  in  `Mem::op_t`  LB, LH, LW, LBU, LHU, SB, SH, SW
- `ex_addr`  in  32  byte address
- `ex_wdata`  in  32  store data (low bits significant for SB/SH)
- `ex_rd`  in  5  load destination register
- `wb_valid`  out  1  load result valid (1-cycle pulse)
- `wb_rd`  out  5  destination of result
- `wb_data`  out  32  formatted load result
- `st_done`  out  1  store accepted downstream (1-cycle pulse)
- `exc_valid`  out  1  misaligned-access exception (1-cycle pulse)
- `exc_store`  out  1  1 = store, 0 = load misaligned
- `exc_addr`  out  32  faulting byte address
- `retry_cnt`  out  `CNT_W`  saturating count of reissue cycles
- `dmem`  `l1dcache_core_if.Client`  request/response to store queue

## Operation
- States: IDLE (nothing outstanding), PEND (request issued previous cycle, response due this cycle).
- `ex_ready = (state == IDLE) || dmem.resp_ack`.
- Accepted aligned op: request driven combinationally from `ex_*` in the accept cycle; op, `addr[1:0]`, rd, req fields captured into a hold register; next state PEND.
- Request fields: `req_addr = addr[31:2]`; `req_we` = store; mask LB/LBU/SB `4'b0001 << addr[1:0]`, LH/LHU/SH `4'b0011 << addr[1:0]`, LW/SW `4'b1111`; data SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`; loads drive data 0.
- PEND with `resp_ack`: complete. Load: `wb_valid=1`, `wb_data` = byte/half of `resp_data` selected by held `addr[1:0]`, sign-extended (LB, LH) or zero-extended (LBU, LHU); LW passes through. Store: `st_done=1`. A new op may be accepted and issued the same cycle (back-to-back); otherwise next state IDLE.
- PEND without `resp_ack`: reissue held request unchanged this cycle, stay PEND, `ex_ready=0`, `retry_cnt` += 1 (saturates at all-ones).
- Misaligned (LH/LHU/SH with `addr[0]`, LW/SW with `addr[1:0]!=0`): accepted, no request issued, state unchanged (IDLE, or IDLE after completion), `exc_valid/exc_store/exc_addr` registered, visible next cycle.
- `dmem.req_valid=0` and all req fields 0 when no issue/reissue.

## Timing
- Reset: state IDLE, hold register 0, `retry_cnt=0`; `wb_valid`, `st_done`, `exc_valid`, `exc_store` 0; `exc_addr`, `wb_data`, `wb_rd` 0; `ex_ready=1`.
- Reset mid-op: outstanding request abandoned; no `wb_valid`/`st_done` produced for it; ack in the cycle after reset ignored.
- Load-use latency: accept cycle N, `wb_valid` earliest N+1; each missing ack adds 1 cycle.
- Peak throughput: one op per cycle while every response acks.
- `wb_valid`, `st_done`, `exc_valid` mutually exclusive only per-source; `exc_valid` (op N) and `wb_valid` (op N-1) never overlap because a misaligned op accepted at N reports at N+1 while op N-1 completed at N.
- Response is sampled only in PEND; `resp_ack` in IDLE is ignored.

## Structure
- `Mem` package: `op_t` enum, `waddr_t`, `w_t`, functions `access_mask(op, off)`, `is_misaligned(op, off)`, `is_store(op)`.
- Sub-module `mem_load_align`: combinational extraction/extension of load data from `resp_data`, held op and offset.
- FSM, hold register and counter in `mem_access_unit`.

## Test plan
- LW `0x100`, resp_ack at N+1 with data `0xDEADBEEF` -> req_addr `0x40`, mask `1111`; `wb_valid`, `wb_data=0xDEADBEEF` at N+1.
- LB `0x103`, resp_data `0x80xxxxxx` -> mask `1000`, `wb_data=0xFFFFFF80`; LBU same -> `0x00000080`; LH `0x102` resp `0x8001xxxx` -> `0xFFFF8001`.
- SH `0x206`, wdata `0x1234ABCD`, ack withheld 2 cycles -> req reissued identical (mask `1100`, data `0xABCDABCD`) twice, `ex_ready=0`, `retry_cnt=2`, `st_done` on 3rd response cycle.
- SW `0x301` -> no `req_valid`; next cycle `exc_valid=1`, `exc_store=1`, `exc_addr=0x301`.
- Back-to-back LW, SB, LW all acked -> three consecutive request cycles, `ex_ready` held 1, completions in order.
- `rst` asserted while PEND, ack next cycle -> no `wb_valid`, state IDLE, `retry_cnt=0`.
